// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and default operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_sub_fs.sv
// serial_sub_fs: 1-bit full subtractor, x - y - bin
module serial_sub_fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, LSB first, one bit per cycle
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_input,
    output logic             ready,
    output logic [WIDTH-1:0] d,
    output logic             b_output,
    output logic             v,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             br, a_msb, b_msb, fd, fb;

    serial_sub_fs fs (.x(sa[0]), .y(sb[0]), .bin(br), .d(fd), .bout(fb));

    assign ready = state == IDLE;

    // operand MSBs are kept aside since the shift registers lose them during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            d        <= '0;
            b_output <= 1'b0;
            v        <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sa    <= a;
                    sb    <= b;
                    br    <= b_input;
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    br    <= fb;
                    sr    <= {fd, sr[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    state <= cnt == LAST ? DONE : RUN;
                end
                DONE: begin
                    d        <= sr;
                    b_output <= br;
                    v        <= (a_msb != b_msb) & (sr[WIDTH-1] != a_msb);
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=4
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       b_input = 1'b0;
    logic       ready, b_output, v, done;
    logic [3:0] d;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       v;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    logic [3:0] last_d = '0;

    serial_sub #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .b_input(b_input),
        .ready(ready), .d(d), .b_output(b_output), .v(v), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [3:0] xa, input logic [3:0] xb, input logic xbi, input int c);
        logic [4:0] f;
        f = {1'b0, xa} - {1'b0, xb} - {4'b0, xbi};
        model.d   = f[3:0];
        model.bo  = f[4];
        model.v   = (xa[3] != xb[3]) && (f[3] != xa[3]);
        model.cyc = c;
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (q.size() == 0) check("spurious_done", 1, 0);
            else begin
                mon_e = q.pop_front();
                check("d", d, mon_e.d);
                check("b_output", b_output, mon_e.bo);
                check("v", v, mon_e.v);
                check("latency", cyc, mon_e.cyc);
                check("ready_at_done", ready, 1);
                last_d = mon_e.d;
            end
        end
    end

    task automatic op(input logic [3:0] xa, input logic [3:0] xb, input logic xbi);
        @(negedge clk);
        a = xa; b = xb; b_input = xbi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q.push_back(model(xa, xb, xbi, cyc + 5));
        check("busy", ready, 0);
        @(negedge clk);
        check("hold_d", d, last_d);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_d", d, 0);
        check("rst_bo", b_output, 0);
        check("rst_v", v, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        op(4'd5, 4'd3, 1'b0); wait_idle();
        op(4'd3, 4'd5, 1'b0); wait_idle();
        op(4'd0, 4'd0, 1'b1); wait_idle();
        op(4'h8, 4'd1, 1'b0); wait_idle();
        op(4'h7, 4'hF, 1'b0); wait_idle();

        // start and operand changes during RUN must be ignored
        op(4'hA, 4'h3, 1'b0);
        a = 4'hF; b = 4'h1; b_input = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'h2;
        wait_idle();

        // start held high: back-to-back every 6 cycles
        @(negedge clk);
        a = 4'd1; b = 4'd2; b_input = 1'b0; start = 1'b1;
        @(negedge clk);
        q.push_back(model(4'd1, 4'd2, 1'b0, cyc + 5));
        q.push_back(model(4'd9, 4'd4, 1'b1, cyc + 11));
        q.push_back(model(4'd6, 4'hB, 1'b0, cyc + 17));
        @(negedge clk);
        a = 4'd9; b = 4'd4; b_input = 1'b1;
        repeat (6) @(negedge clk);
        a = 4'd6; b = 4'hB; b_input = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset during the second RUN cycle aborts the operation
        @(negedge clk);
        a = 4'hC; b = 4'h4; b_input = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_d", d, 0);
        check("abort_bo", b_output, 0);
        check("abort_v", v, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_d = '0;
        repeat (10) @(negedge clk);
        check("post_abort_d", d, 0);
        check("post_abort_ready", ready, 1);
        op(4'd5, 4'd3, 1'b0); wait_idle();
        op(4'h2, 4'h9, 1'b1); wait_idle();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
